// File: rtl/sort3_arb.sv
// Round-robin front end that shares one fixed-latency 3-input sorter between two
// requesters, steering each sorted result back to its issuer via a tag pipeline.
module sort3_arb #(
    parameter int WIDTH = 3,
    parameter int LAT   = 1,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req0_c,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [WIDTH-1:0] req1_c,
    output logic             req1_ready,
    output logic [WIDTH-1:0] srt_a,
    output logic [WIDTH-1:0] srt_b,
    output logic [WIDTH-1:0] srt_c,
    input  logic [WIDTH-1:0] srt_no1,
    input  logic [WIDTH-1:0] srt_no2,
    input  logic [WIDTH-1:0] srt_no3,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_no1,
    output logic [WIDTH-1:0] rsp_no2,
    output logic [WIDTH-1:0] rsp_no3,
    output logic             busy,
    output logic [CNTW-1:0]  gnt0_cnt,
    output logic [CNTW-1:0]  gnt1_cnt
);

    logic           last;       // requester granted most recently
    logic           gnt0;
    logic           gnt1;
    logic           accept;
    logic [LAT-1:0] tag_v;
    logic [LAT-1:0] tag_id;

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last;
                gnt1 = !last;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign accept     = gnt0 | gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        srt_a = '0;
        srt_b = '0;
        srt_c = '0;
        if (gnt0) begin
            srt_a = req0_a;
            srt_b = req0_b;
            srt_c = req0_c;
        end else if (gnt1) begin
            srt_a = req1_a;
            srt_b = req1_b;
            srt_c = req1_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last       <= 1'b1;
            tag_v      <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_no1    <= '0;
            rsp_no2    <= '0;
            rsp_no3    <= '0;
            gnt0_cnt   <= '0;
            gnt1_cnt   <= '0;
        end else begin
            if (accept) begin
                last <= gnt1;
            end
            // NOTE: non-blocking assignment lets every stage take its neighbour's
            // pre-edge value, so this loop is a true shift register, not a wire.
            tag_v[0] <= accept;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
            end
            rsp0_valid <= tag_v[LAT-1] && !tag_id[LAT-1];
            rsp1_valid <= tag_v[LAT-1] && tag_id[LAT-1];
            if (tag_v[LAT-1]) begin
                rsp_no1 <= srt_no1;
                rsp_no2 <= srt_no2;
                rsp_no3 <= srt_no3;
            end
            if (gnt0) begin
                gnt0_cnt <= gnt0_cnt + CNTW'(1);
            end
            if (gnt1) begin
                gnt1_cnt <= gnt1_cnt + CNTW'(1);
            end
        end
    end

    // NOTE: the id payload is only ever read when its valid bit is set, and the
    // valid bits are reset, so the id pipeline is left without a reset.
    always_ff @(posedge clk) begin
        tag_id[0] <= gnt1;
        for (int i = 1; i < LAT; i++) begin
            tag_id[i] <= tag_id[i-1];
        end
    end

    assign busy = (|tag_v) | rsp0_valid | rsp1_valid;

endmodule
